mmu_result_drain: RTL
=====================

Name: mmu_result_drain

Overview:
- Sits directly downstream of the MMU feeder/systolic array.
- On a capture strobe, snapshots the four 16-bit accumulations c_0..c_3 into a holding buffer.
- Streams the snapshot to the host one byte per read strobe over the 8-bit output bus, and raises done while unread data remains.
- Frees the MMU to clear and start the next product while the host drains the previous result.

Parameters:
- SAT8, 0, 0 = send each element as two bytes (low then high); 1 = clamp each element to unsigned 8 bits and send one byte each.
- ELEMS, 4, number of accumulations captured; fixed at 4 for the 2x2 array.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- capture  input  1  one-cycle strobe from feeder: latch c_0..c_3 this cycle
- c_0  input  16  accumulation element (0,0)
- c_1  input  16  accumulation element (0,1)
- c_2  input  16  accumulation element (1,0)
- c_3  input  16  accumulation element (1,1)
- host_rd  input  1  one-cycle strobe from control unit: host consumed current byte
- clr_flags  input  1  clears sticky overrun/clamped flags
- host_outdata  output  8  current byte presented to host
- done  output  1  high while snapshot holds unread bytes
- overrun  output  1  sticky: capture arrived before previous snapshot fully read
- clamped  output  1  sticky: SAT8=1 and some captured element exceeded 255

Behaviour:
- Reset (async, rst=1): state IDLE; buffer=0; rd_ptr=0; host_outdata=0; done=0; overrun=0; clamped=0.
- NBYTES = 8 when SAT8=0, else 4. rd_ptr is 3 bits wide.
- Byte order, SAT8=0: c_0[7:0], c_0[15:8], c_1[7:0], c_1[15:8], c_2 lo, c_2 hi, c_3 lo, c_3 hi.
- Byte order, SAT8=1: sat(c_0), sat(c_1), sat(c_2), sat(c_3), where sat(x) = (x > 255) ? 8'hFF : x[7:0]. Elements are treated as unsigned.
- States: IDLE, READY.
- IDLE:
  - host_outdata=0, done=0.
  - capture=1 -> latch all four elements (saturated if SAT8), rd_ptr=0, go to READY.
  - host_rd ignored.
- READY:
  - done=1; host_outdata = registered byte[rd_ptr].
  - host_rd=1 -> rd_ptr+1. Next byte appears the cycle after the strobe (1-cycle latency).
  - host_rd=1 when rd_ptr=NBYTES-1 -> go to IDLE; done=0 and host_outdata=0 next cycle; rd_ptr wraps to 0.
- Capture in READY (including the same cycle as host_rd):
  - Capture wins: new snapshot loaded, rd_ptr=0, stays in READY; that host_rd is discarded.
  - overrun set if any byte of the old snapshot was unread (always true in READY).
- clamped is set on a capture cycle if SAT8=1 and any c_i > 255. It is never set when SAT8=0.
- clr_flags=1 clears overrun and clamped next cycle. If a set condition occurs in the same cycle, set wins.
- Reset mid-stream: immediate return to reset values; the partially read snapshot is lost.
- host_outdata is registered (no combinational path from c_i). Values are stable between host_rd strobes.
- Back-to-back host_rd on consecutive cycles is legal; one byte advances per strobe.
- host_rd held high for N cycles is N reads.

Test Plan:
- Basic drain, SAT8=0: capture with c_0=16'h1234, c_1=16'hABCD, c_2=16'h0001, c_3=16'hFFFF; then 8 host_rd strobes -> bytes 34,12,CD,AB,01,00,FF,FF. done=1 from the cycle after capture until the cycle after the 8th read; then host_outdata=00 and done=0.
- Saturation, SAT8=1: c_0=200, c_1=256, c_2=16'h8000, c_3=0 -> bytes C8,FF,FF,00; clamped=1 after capture; 4 reads return to IDLE; clr_flags -> clamped=0.
- Overrun: capture A, read 3 bytes, capture B (c_0=16'h00AA) in the same cycle as host_rd -> rd_ptr=0, host_outdata=AA next cycle, overrun=1, done stays 1.
- Idle reads: host_rd pulses with no capture -> host_outdata=00, done=0, no state change.
- Async reset mid-stream: capture, read 2 bytes, assert rst between clock edges -> outputs 0 and flags 0 immediately. After release, host_rd has no effect until the next capture.
- Flag priority: clr_flags and an overrun-causing capture in the same cycle -> overrun=1.

Source files
------------

// File: rtl/mmu_result_drain_if.sv
// Result drain bus: MMU capture strobe and accumulations in, host byte stream and status out.
interface mmu_result_drain_if;
  logic        capture;
  logic [15:0] c_0;
  logic [15:0] c_1;
  logic [15:0] c_2;
  logic [15:0] c_3;
  logic        host_rd;
  logic        clr_flags;
  logic [7:0]  host_outdata;
  logic        done;
  logic        overrun;
  logic        clamped;

  // Feeder/host side drives strobes and data, observes the byte stream.
  modport master (
    output capture, c_0, c_1, c_2, c_3, host_rd, clr_flags,
    input  host_outdata, done, overrun, clamped
  );

  // Drain block side.
  modport slave (
    input  capture, c_0, c_1, c_2, c_3, host_rd, clr_flags,
    output host_outdata, done, overrun, clamped
  );
endinterface

// File: rtl/mmu_result_drain.sv
// Snapshots the 2x2 MMU accumulations on capture and streams them to the host
// one byte per host_rd, so the array can start the next product meanwhile.
module mmu_result_drain #(
  parameter bit SAT8 = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  mmu_result_drain_if.slave   bus
);

  localparam int unsigned ELEMS  = 4;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAXB   = 8;
  localparam int unsigned NBYTES = SAT8 ? 4 : 8;
  localparam int unsigned PTR_W  = 3;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NBYTES - 1);
  localparam logic [ELEM_W-1:0] SAT_MAX  = ELEM_W'(255);

  typedef enum logic {IDLE, READY} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0]   buf_q [MAXB];
  logic [BYTE_W-1:0]   buf_d [MAXB];
  logic [BYTE_W-1:0]   snap  [MAXB];
  logic [BYTE_W-1:0]   host_outdata_q, host_outdata_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                clamped_q, clamped_d;
  logic [ELEM_W-1:0]   elem [ELEMS];
  logic                any_over;

  assign elem[0] = bus.c_0;
  assign elem[1] = bus.c_1;
  assign elem[2] = bus.c_2;
  assign elem[3] = bus.c_3;

  // Byte image of the incoming accumulations as it would be stored on capture.
  always_comb begin
    any_over = 1'b0;
    for (int i = 0; i < MAXB; i++) snap[i] = '0;
    for (int i = 0; i < ELEMS; i++) begin
      any_over = any_over | (elem[i] > SAT_MAX);
      if (SAT8) begin
        snap[i] = (elem[i] > SAT_MAX) ? 8'hFF : elem[i][7:0];
      end else begin
        snap[2*i]     = elem[i][7:0];
        snap[2*i + 1] = elem[i][15:8];
      end
    end
  end

  // Next state, buffer, read pointer, sticky flags and registered outputs.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    buf_d     = buf_q;
    overrun_d = bus.clr_flags ? 1'b0 : overrun_q;
    clamped_d = bus.clr_flags ? 1'b0 : clamped_q;

    case (state_q)
      IDLE: begin
        if (bus.capture) begin
          buf_d    = snap;
          rd_ptr_d = '0;
          state_d  = READY;
        end
      end
      READY: begin
        // A capture always lands on unread bytes here; it wins over host_rd.
        if (bus.capture) begin
          buf_d     = snap;
          rd_ptr_d  = '0;
          overrun_d = 1'b1;
        end else if (bus.host_rd) begin
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            state_d  = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        rd_ptr_d = '0;
      end
    endcase

    if (SAT8 && bus.capture && any_over) clamped_d = 1'b1;

    done_d         = (state_d == READY);
    host_outdata_d = (state_d == READY) ? buf_d[rd_ptr_d] : '0;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rd_ptr_q       <= '0;
      for (int i = 0; i < MAXB; i++) buf_q[i] <= '0;
      host_outdata_q <= '0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      clamped_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      buf_q          <= buf_d;
      host_outdata_q <= host_outdata_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      clamped_q      <= clamped_d;
    end
  end

  assign bus.host_outdata = host_outdata_q;
  assign bus.done         = done_q;
  assign bus.overrun      = overrun_q;
  assign bus.clamped      = clamped_q;

endmodule
